// File: rtl/caliptra_prim_onehot_dec.sv
// One-hot to binary decoder with a single valid/ready output register and
// error statistics (sticky flag plus saturating error counter).
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_i, in_valid_i    one-hot vector to decode and its valid strobe
//   in_ready_o          input accepted this cycle when in_valid_i is high
//   out_o               decoded index (0 unless out_en_o)
//   out_en_o            out_o holds a legal nonzero decode
//   out_err_o           transaction was not a legal code
//   out_valid_o         output payload valid
//   out_ready_i         downstream accepts the output
//   clr_i               synchronous clear of the error statistics
//   err_sticky_o        at least one error since reset or last clear
//   err_cnt_o           saturating count of errored transactions
module caliptra_prim_onehot_dec #(
  parameter int unsigned OneHotWidth = 32,
  parameter bit          AllowZero   = 1'b1,
  localparam int unsigned OutputWidth = $clog2(OneHotWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [OneHotWidth-1:0] in_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [OutputWidth-1:0] out_o,
  output logic                   out_en_o,
  output logic                   out_err_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  input  logic                   clr_i,
  output logic                   err_sticky_o,
  output logic [7:0]             err_cnt_o
);

  localparam int unsigned CntWidth = 8;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic                   any_set;
  logic                   multi_set;
  logic [OutputWidth-1:0] dec_idx;
  logic                   dec_legal;
  logic                   dec_err;
  logic                   accept;
  logic                   err_accept;

  // Scan the input: remember the last set position and flag a second set bit.
  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    dec_idx   = '0;
    for (int unsigned i = 0; i < OneHotWidth; i++) begin
      if (in_i[i]) begin
        if (any_set) begin
          multi_set = 1'b1;
        end
        any_set = 1'b1;
        dec_idx = OutputWidth'(i);
      end
    end
  end

  assign dec_legal  = any_set && !multi_set;
  assign dec_err    = multi_set || (!any_set && !AllowZero);

  // Single output stage: a new input may enter whenever the stage is empty
  // or is being drained in the same cycle.
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign err_accept = accept && dec_err;

  // Output register; payload only changes on acceptance, so it holds under stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_o       <= '0;
      out_en_o    <= 1'b0;
      out_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_o <= 1'b1;
        out_o       <= dec_legal ? dec_idx : '0;
        out_en_o    <= dec_legal;
        out_err_o   <= dec_err;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  // Error statistics; a clear coinciding with a new error restarts the count at 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_sticky_o <= 1'b0;
      err_cnt_o    <= '0;
    end else if (clr_i) begin
      err_sticky_o <= err_accept;
      err_cnt_o    <= err_accept ? CntWidth'(1) : '0;
    end else if (err_accept) begin
      err_sticky_o <= 1'b1;
      if (err_cnt_o != CntMax) begin
        err_cnt_o <= err_cnt_o + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_caliptra_prim_onehot_dec.sv
// Directed self-checking bench for caliptra_prim_onehot_dec (OneHotWidth=32).
// A second instance with AllowZero=0 shares the stimulus to cover the
// zero-is-error variant.
module tb_caliptra_prim_onehot_dec;

  logic        clk;
  logic        rst;
  logic [31:0] in_v;
  logic        in_valid;
  logic        out_ready;
  logic        clr;

  logic        in_ready;
  logic [4:0]  out_idx;
  logic        out_en;
  logic        out_err;
  logic        out_valid;
  logic        err_sticky;
  logic [7:0]  err_cnt;

  logic        nz_in_ready;
  logic [4:0]  nz_out_idx;
  logic        nz_out_en;
  logic        nz_out_err;
  logic        nz_out_valid;
  logic        nz_err_sticky;
  logic [7:0]  nz_err_cnt;

  int checks   = 0;
  int failures = 0;

  caliptra_prim_onehot_dec #(.OneHotWidth(32), .AllowZero(1'b1)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_i        (in_v),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_o       (out_idx),
    .out_en_o    (out_en),
    .out_err_o   (out_err),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .clr_i       (clr),
    .err_sticky_o(err_sticky),
    .err_cnt_o   (err_cnt)
  );

  caliptra_prim_onehot_dec #(.OneHotWidth(32), .AllowZero(1'b0)) u_dut_nz (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_i        (in_v),
    .in_valid_i  (in_valid),
    .in_ready_o  (nz_in_ready),
    .out_o       (nz_out_idx),
    .out_en_o    (nz_out_en),
    .out_err_o   (nz_out_err),
    .out_valid_o (nz_out_valid),
    .out_ready_i (out_ready),
    .clr_i       (clr),
    .err_sticky_o(nz_err_sticky),
    .err_cnt_o   (nz_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] idx,
                         input logic en, input logic er);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".en"},    32'(out_en),    32'(en));
    chk({tag, ".err"},   32'(out_err),   32'(er));
  endtask

  initial begin
    rst = 1'b0; in_v = '0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_out("reset", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("reset.sticky", 32'(err_sticky), 32'd0);
    chk("reset.cnt", 32'(err_cnt), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    #9 rst = 1'b0;
    chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    // Legal codes, including both ends of the vector.
    in_valid = 1'b1; in_v = 32'h0000_0400;
    tick();
    chk_out("legal_bit10", 1'b1, 5'd10, 1'b1, 1'b0);
    in_v = 32'h8000_0000;
    tick();
    chk_out("legal_bit31", 1'b1, 5'd31, 1'b1, 1'b0);
    in_v = 32'h0000_0001;
    tick();
    chk_out("legal_bit0", 1'b1, 5'd0, 1'b0 + 1'b1, 1'b0);

    // All-zero: disabled code here, error in the AllowZero=0 instance.
    in_v = 32'h0;
    tick();
    chk_out("zero", 1'b1, 5'd0, 1'b0, 1'b0);
    chk("zero.cnt", 32'(err_cnt), 32'd0);
    chk("zero.sticky", 32'(err_sticky), 32'd0);
    chk("nz_zero.valid", 32'(nz_out_valid), 32'd1);
    chk("nz_zero.idx", 32'(nz_out_idx), 32'd0);
    chk("nz_zero.en", 32'(nz_out_en), 32'd0);
    chk("nz_zero.err", 32'(nz_out_err), 32'd1);
    chk("nz_zero.cnt", 32'(nz_err_cnt), 32'd1);
    chk("nz_zero.sticky", 32'(nz_err_sticky), 32'd1);
    chk("nz_zero.in_ready", 32'(nz_in_ready), 32'd1);

    // Multi-hot.
    in_v = 32'h0000_0011;
    tick();
    chk_out("multi", 1'b1, 5'd0, 1'b0, 1'b1);
    chk("multi.cnt", 32'(err_cnt), 32'd1);
    chk("multi.sticky", 32'(err_sticky), 32'd1);

    // Drain, then backpressure one transaction for 5 cycles.
    in_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_v = 32'h0000_0020; out_ready = 1'b0;
    tick();
    chk_out("bp_first", 1'b1, 5'd5, 1'b1, 1'b0);
    in_v = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("bp_hold", 1'b1, 5'd5, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_next", 1'b1, 5'd6, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("handshake_clears.valid", 32'(out_valid), 32'd0);
    chk("bp.cnt", 32'(err_cnt), 32'd1);

    // Bring count to 7, then clear colliding with an error.
    in_valid = 1'b1; in_v = 32'h0000_0003;
    repeat (6) tick();
    chk("to7.cnt", 32'(err_cnt), 32'd7);
    clr = 1'b1;
    tick();
    chk("clr_collide.cnt", 32'(err_cnt), 32'd1);
    chk("clr_collide.sticky", 32'(err_sticky), 32'd1);
    chk("clr_collide.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("clr_plain.cnt", 32'(err_cnt), 32'd0);
    chk("clr_plain.sticky", 32'(err_sticky), 32'd0);
    clr = 1'b0;

    // 300 back-to-back multi-hot transactions saturate the counter.
    in_valid = 1'b1; in_v = 32'hFFFF_FFFF;
    repeat (254) tick();
    chk("sat.cnt254", 32'(err_cnt), 32'd254);
    repeat (46) tick();
    chk("sat.cnt255", 32'(err_cnt), 32'd255);
    chk("sat.sticky", 32'(err_sticky), 32'd1);
    in_valid = 1'b0; clr = 1'b1;
    tick();
    chk("sat_clr.cnt", 32'(err_cnt), 32'd0);
    chk("sat_clr.sticky", 32'(err_sticky), 32'd0);
    clr = 1'b0;

    // Reset mid-operation with a pending output and count 3.
    in_valid = 1'b1; in_v = 32'h0000_0300;
    repeat (3) tick();
    chk("pre_rst.cnt", 32'(err_cnt), 32'd3);
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("mid_rst.cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst.sticky", 32'(err_sticky), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    tick();
    chk("after_rst.valid", 32'(out_valid), 32'd0);
    chk("after_rst.in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
